hazard_scoreboard: RTL and testbench

Parametrised hazard and forwarding unit for the in-order pipeline: IF, ID, EX, MEM and WB. It keeps a per-register scoreboard of in-flight writes from ID→EX issue to WB retire, and generates per-source forwarding selects and ID stall. It covers variable-latency sources: AXI loads, mfc0 and the multi-cycle divider. A small FSM tracks the divider and holds EX while it runs.

---
 rtl/hazard_pkg.sv | 18 +
 rtl/sb_cnt.sv | 50 +++++
 rtl/hazard_scoreboard.sv | 162 ++++++++++++++++
 tb/tb_hazard_scoreboard.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// Shared constants and types for the pipeline hazard/forwarding unit.
package hazard_pkg;

    // Forwarding select encodings, one 2-bit field per ID source operand.
    localparam logic [1:0] FWD_RF = 2'b00;
    localparam logic [1:0] FWD_ES = 2'b01;
    localparam logic [1:0] FWD_MS = 2'b10;
    localparam logic [1:0] FWD_WS = 2'b11;

    localparam int unsigned FWD_W = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BUSY  = 2'd1,
        DRAIN = 2'd2
    } div_state_t;

endpackage

// File: rtl/sb_cnt.sv
// One scoreboard entry: saturating up/down count of in-flight writes to a
// single GPR, with synchronous clear for pipeline flush.
module sb_cnt
    import hazard_pkg::*;
#(
    parameter int unsigned CNT_W = 2
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             clr,
    input  logic             inc,
    input  logic             dec,
    output logic [CNT_W-1:0] cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic             w_up;
    logic             w_dn;
    logic [CNT_W-1:0] r_cnt;

    // A simultaneous issue and retire on the same register cancel out.
    assign w_up = inc && !dec;
    assign w_dn = dec && !inc;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_cnt <= '0;
        end else if (clr) begin
            r_cnt <= '0;
        end else if (w_up && (r_cnt != CNT_MAX)) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end else if (w_dn && (r_cnt != '0)) begin
            r_cnt <= r_cnt - CNT_W'(1);
        end
    end

    assign cnt = r_cnt;

`ifndef SYNTHESIS
    a_no_overflow: assert property (@(posedge clk) disable iff (!resetn)
        !(!clr && w_up && (r_cnt == CNT_MAX)))
        else $error("sb_cnt: increment at maximum count");

    a_no_underflow: assert property (@(posedge clk) disable iff (!resetn)
        !(!clr && w_dn && (r_cnt == '0)))
        else $error("sb_cnt: decrement at zero count");
`endif

endmodule

// File: rtl/hazard_scoreboard.sv
// Hazard/forwarding unit for the 5-stage in-order pipeline: per-GPR pending
// write scoreboard, per-source forwarding selects, ID stall and divider hold.
module hazard_scoreboard
    import hazard_pkg::*;
#(
    parameter int unsigned NREG  = 32,
    parameter int unsigned AW    = 5,
    parameter int unsigned NSRC  = 2,
    parameter int unsigned CNT_W = 2
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  flush,
    input  logic                  ds_valid,
    input  logic [NSRC*AW-1:0]    ds_raddr,
    input  logic                  issue,
    input  logic [AW-1:0]         issue_dest,
    input  logic                  issue_gr_we,
    input  logic                  es_valid,
    input  logic                  ms_valid,
    input  logic                  ws_valid,
    input  logic [AW-1:0]         es_dest,
    input  logic [AW-1:0]         ms_dest,
    input  logic [AW-1:0]         ws_dest,
    input  logic                  es_gr_we,
    input  logic                  ms_gr_we,
    input  logic                  ws_gr_we,
    input  logic                  es_data_ok,
    input  logic                  ms_data_ok,
    input  logic                  retire,
    input  logic                  div_start,
    input  logic                  div_done,
    output logic [NSRC*FWD_W-1:0] fwd_sel,
    output logic                  ds_stall,
    output logic                  es_stall,
    output logic                  div_ready,
    output logic [NREG-1:0]       pending
);

    logic [CNT_W-1:0] w_cnt [NREG];
    logic [NSRC-1:0]  w_src_stall;
    logic             w_es_wr;
    logic             w_ms_wr;
    logic             w_ws_wr;
    div_state_t       r_div_state;
    div_state_t       w_div_state_nxt;

    assign w_cnt[0]   = '0;
    assign pending[0] = 1'b0;

    // Scoreboard entries for r1..r(NREG-1); flush wins over issue and retire.
    for (genvar r = 1; r < NREG; r++) begin : g_cnt
        sb_cnt #(
            .CNT_W (CNT_W)
        ) u_cnt (
            .clk    (clk),
            .resetn (resetn),
            .clr    (flush),
            .inc    (issue && issue_gr_we && (issue_dest == AW'(r))),
            .dec    (retire && (ws_dest == AW'(r))),
            .cnt    (w_cnt[r])
        );

        assign pending[r] = (w_cnt[r] != '0);
    end

    assign w_es_wr = es_valid && es_gr_we;
    assign w_ms_wr = ms_valid && ms_gr_we;
    assign w_ws_wr = ws_valid && ws_gr_we;

    // Per-source select: youngest matching producer wins, stall if its data
    // is not final or if the producer is pending but sitting in a bubble.
    for (genvar i = 0; i < NSRC; i++) begin : g_src
        logic [AW-1:0]    w_addr;
        logic             w_es_hit;
        logic             w_ms_hit;
        logic             w_ws_hit;
        logic [FWD_W-1:0] w_sel;
        logic             w_stall;

        assign w_addr   = ds_raddr[i*AW +: AW];
        assign w_es_hit = w_es_wr && (es_dest == w_addr);
        assign w_ms_hit = w_ms_wr && (ms_dest == w_addr);
        assign w_ws_hit = w_ws_wr && (ws_dest == w_addr);

        always_comb begin
            w_sel   = FWD_RF;
            w_stall = 1'b0;
            if (w_addr != '0) begin
                if (w_es_hit) begin
                    if (es_data_ok) begin
                        w_sel = FWD_ES;
                    end else begin
                        w_stall = 1'b1;
                    end
                end else if (w_ms_hit) begin
                    if (ms_data_ok) begin
                        w_sel = FWD_MS;
                    end else begin
                        w_stall = 1'b1;
                    end
                end else if (w_ws_hit) begin
                    w_sel = FWD_WS;
                end else if (w_cnt[w_addr] != '0) begin
                    w_stall = 1'b1;
                end
            end
        end

        assign fwd_sel[i*FWD_W +: FWD_W] = w_sel;
        assign w_src_stall[i]            = w_stall;
    end

    assign ds_stall = ds_valid && (|w_src_stall);

    // Divider tracker state register.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_div_state <= IDLE;
        end else begin
            r_div_state <= w_div_state_nxt;
        end
    end

    // DRAIN waits out a divide whose owner was flushed, without holding EX.
    always_comb begin
        w_div_state_nxt = r_div_state;
        es_stall        = 1'b0;
        div_ready       = 1'b0;
        unique case (r_div_state)
            IDLE: begin
                div_ready = 1'b1;
                if (div_start) begin
                    w_div_state_nxt = BUSY;
                end
            end
            BUSY: begin
                es_stall = !div_done;
                if (div_done) begin
                    w_div_state_nxt = IDLE;
                end else if (flush) begin
                    w_div_state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                if (div_done) begin
                    w_div_state_nxt = IDLE;
                end
            end
            default: begin
                w_div_state_nxt = IDLE;
            end
        endcase
    end

`ifndef SYNTHESIS
    a_div_start_idle: assert property (@(posedge clk) disable iff (!resetn)
        !(div_start && (r_div_state != IDLE)))
        else $error("hazard_scoreboard: div_start while divider not idle");
`endif

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed checks of forwarding selects, stalls, scoreboard and divider FSM.
module tb_hazard_scoreboard;
    import hazard_pkg::*;

    localparam int unsigned NREG  = 32;
    localparam int unsigned AW    = 5;
    localparam int unsigned NSRC  = 2;
    localparam int unsigned CNT_W = 2;

    logic              clk = 1'b0;
    logic              resetn;
    logic              flush;
    logic              ds_valid;
    logic [NSRC*AW-1:0] ds_raddr;
    logic              issue;
    logic [AW-1:0]     issue_dest;
    logic              issue_gr_we;
    logic              es_valid, ms_valid, ws_valid;
    logic [AW-1:0]     es_dest, ms_dest, ws_dest;
    logic              es_gr_we, ms_gr_we, ws_gr_we;
    logic              es_data_ok, ms_data_ok;
    logic              retire;
    logic              div_start, div_done;
    logic [NSRC*2-1:0] fwd_sel;
    logic              ds_stall, es_stall, div_ready;
    logic [NREG-1:0]   pending;

    int n_vec  = 0;
    int n_fail = 0;

    hazard_scoreboard #(
        .NREG (NREG), .AW (AW), .NSRC (NSRC), .CNT_W (CNT_W)
    ) dut (
        .clk (clk), .resetn (resetn), .flush (flush),
        .ds_valid (ds_valid), .ds_raddr (ds_raddr),
        .issue (issue), .issue_dest (issue_dest), .issue_gr_we (issue_gr_we),
        .es_valid (es_valid), .ms_valid (ms_valid), .ws_valid (ws_valid),
        .es_dest (es_dest), .ms_dest (ms_dest), .ws_dest (ws_dest),
        .es_gr_we (es_gr_we), .ms_gr_we (ms_gr_we), .ws_gr_we (ws_gr_we),
        .es_data_ok (es_data_ok), .ms_data_ok (ms_data_ok),
        .retire (retire), .div_start (div_start), .div_done (div_done),
        .fwd_sel (fwd_sel), .ds_stall (ds_stall), .es_stall (es_stall),
        .div_ready (div_ready), .pending (pending)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        n_vec++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp_v);
        end
    endtask

    task automatic idle();
        flush = 0; ds_valid = 0; ds_raddr = '0;
        issue = 0; issue_dest = '0; issue_gr_we = 0;
        es_valid = 0; ms_valid = 0; ws_valid = 0;
        es_dest = '0; ms_dest = '0; ws_dest = '0;
        es_gr_we = 0; ms_gr_we = 0; ws_gr_we = 0;
        es_data_ok = 0; ms_data_ok = 0; retire = 0;
        div_start = 0; div_done = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_issue(input logic [AW-1:0] d);
        issue = 1; issue_dest = d; issue_gr_we = 1;
    endtask

    task automatic set_es(input logic [AW-1:0] d, input logic ok);
        es_valid = 1; es_dest = d; es_gr_we = 1; es_data_ok = ok;
    endtask

    task automatic set_ms(input logic [AW-1:0] d, input logic ok);
        ms_valid = 1; ms_dest = d; ms_gr_we = 1; ms_data_ok = ok;
    endtask

    task automatic set_ws_retire(input logic [AW-1:0] d);
        ws_valid = 1; ws_dest = d; ws_gr_we = 1; retire = 1;
    endtask

    task automatic read_src(input logic [AW-1:0] a0, input logic [AW-1:0] a1);
        ds_valid = 1; ds_raddr = {a1, a0};
    endtask

    initial begin
        idle();
        resetn = 0;
        #1;
        chk("rst_pending", 64'(pending), 64'h0);
        chk("rst_div_ready", 64'(div_ready), 64'h1);
        chk("rst_es_stall", 64'(es_stall), 64'h0);
        chk("rst_ds_stall", 64'(ds_stall), 64'h0);
        chk("rst_fwd_sel", 64'(fwd_sel), 64'h0);
        repeat (2) @(negedge clk);
        resetn = 1;
        tick();

        // ALU chain on r3: EX, then MEM, then WB forwarding
        idle(); do_issue(5'd3);
        tick();
        chk("alu_pend3", 64'(pending), 64'h8);
        idle(); set_es(5'd3, 1); read_src(5'd3, 5'd0);
        #1;
        chk("alu_fwd_es", 64'(fwd_sel), 64'h1);
        chk("alu_nostall_es", 64'(ds_stall), 64'h0);
        tick();
        idle(); set_ms(5'd3, 1); read_src(5'd3, 5'd3);
        #1;
        chk("alu_fwd_ms", 64'(fwd_sel), 64'ha);
        tick();
        idle(); set_ws_retire(5'd3); read_src(5'd3, 5'd3);
        #1;
        chk("alu_fwd_ws", 64'(fwd_sel), 64'hf);
        chk("alu_nostall_ws", 64'(ds_stall), 64'h0);
        tick();
        chk("alu_retired", 64'(pending), 64'h0);

        // Load-use on r5 with slow AXI data
        idle(); do_issue(5'd5);
        tick();
        idle(); set_es(5'd5, 0); read_src(5'd5, 5'd0);
        #1;
        chk("ld_es_stall", 64'(ds_stall), 64'h1);
        chk("ld_es_fwd", 64'(fwd_sel), 64'h0);
        tick();
        for (int k = 0; k < 4; k++) begin
            idle(); set_ms(5'd5, 0); read_src(5'd5, 5'd0);
            #1;
            chk($sformatf("ld_ms_wait%0d", k), 64'(ds_stall), 64'h1);
            tick();
        end
        idle(); set_ms(5'd5, 0); ds_valid = 0; ds_raddr = {5'd0, 5'd5};
        #1;
        chk("ld_no_ds_valid", 64'(ds_stall), 64'h0);
        ms_data_ok = 1; ds_valid = 1;
        #1;
        chk("ld_ms_fwd", 64'(fwd_sel), 64'h2);
        chk("ld_ms_go", 64'(ds_stall), 64'h0);
        tick();
        idle(); set_ws_retire(5'd5);
        tick();
        chk("ld_retired", 64'(pending), 64'h0);

        // Double writer on r7
        idle(); do_issue(5'd7);
        tick();
        idle(); do_issue(5'd7); set_es(5'd7, 1);
        tick();
        chk("dw_pend", 64'(pending), 64'h80);
        idle(); set_es(5'd7, 1); set_ms(5'd7, 1); read_src(5'd7, 5'd0);
        #1;
        chk("dw_youngest_es", 64'(fwd_sel), 64'h1);
        es_data_ok = 0;
        #1;
        chk("dw_es_notok_stall", 64'(ds_stall), 64'h1);
        chk("dw_es_notok_fwd", 64'(fwd_sel), 64'h0);
        tick();
        idle(); set_ms(5'd7, 1); set_ws_retire(5'd7); read_src(5'd7, 5'd0);
        #1;
        chk("dw_youngest_ms", 64'(fwd_sel), 64'h2);
        tick();
        chk("dw_one_left", 64'(pending), 64'h80);
        idle(); set_ws_retire(5'd7); do_issue(5'd7);
        tick();
        chk("dw_inc_dec_same", 64'(pending), 64'h80);
        idle(); set_ws_retire(5'd7);
        tick();
        chk("dw_drained", 64'(pending), 64'h0);
        idle(); issue = 1; issue_dest = 5'd8; issue_gr_we = 0;
        tick();
        idle(); do_issue(5'd0);
        tick();
        chk("no_we_or_r0", 64'(pending), 64'h0);

        // Bubble: r9 pending with no stage holding it
        idle(); do_issue(5'd9);
        tick();
        for (int k = 0; k < 2; k++) begin
            idle(); read_src(5'd9, 5'd0);
            #1;
            chk($sformatf("bub_stall%0d", k), 64'(ds_stall), 64'h1);
            tick();
        end
        idle(); set_es(5'd9, 1); read_src(5'd0, 5'd9);
        #1;
        chk("bub_es_fwd", 64'(fwd_sel), 64'h4);
        chk("bub_es_go", 64'(ds_stall), 64'h0);
        idle(); set_es(5'd0, 0); read_src(5'd0, 5'd0);
        #1;
        chk("r0_fwd", 64'(fwd_sel), 64'h0);
        chk("r0_stall", 64'(ds_stall), 64'h0);
        tick();

        // Flush with three pending registers, competing issue and retire
        idle(); do_issue(5'd10);
        tick();
        idle(); do_issue(5'd11);
        tick();
        chk("fl_pend3", 64'(pending), 64'he00);
        idle(); flush = 1; do_issue(5'd12); set_ws_retire(5'd9);
        tick();
        chk("fl_cleared", 64'(pending), 64'h0);

        // Divider normal completion
        idle(); div_start = 1;
        #1;
        chk("dv_start_es", 64'(es_stall), 64'h0);
        tick();
        for (int k = 0; k < 3; k++) begin
            idle();
            #1;
            chk($sformatf("dv_busy_es%0d", k), 64'(es_stall), 64'h1);
            chk($sformatf("dv_busy_rdy%0d", k), 64'(div_ready), 64'h0);
            tick();
        end
        idle(); div_done = 1;
        #1;
        chk("dv_done_es", 64'(es_stall), 64'h0);
        tick();
        idle();
        #1;
        chk("dv_idle_rdy", 64'(div_ready), 64'h1);

        // Divider flushed while busy drains
        idle(); div_start = 1;
        tick();
        idle(); flush = 1;
        #1;
        chk("dv_fl_busy_es", 64'(es_stall), 64'h1);
        tick();
        for (int k = 0; k < 2; k++) begin
            idle();
            #1;
            chk($sformatf("dv_drain_es%0d", k), 64'(es_stall), 64'h0);
            chk($sformatf("dv_drain_rdy%0d", k), 64'(div_ready), 64'h0);
            tick();
        end
        idle(); div_done = 1;
        tick();
        idle();
        #1;
        chk("dv_drain_done_rdy", 64'(div_ready), 64'h1);

        // Reset pulse mid-divide
        idle(); do_issue(5'd4);
        tick();
        idle(); div_start = 1;
        tick();
        idle();
        #1;
        chk("rb_busy_es", 64'(es_stall), 64'h1);
        chk("rb_pend4", 64'(pending), 64'h10);
        resetn = 0;
        #1;
        chk("rb_pend_async", 64'(pending), 64'h0);
        chk("rb_rdy_async", 64'(div_ready), 64'h1);
        chk("rb_es_async", 64'(es_stall), 64'h0);
        @(negedge clk);
        resetn = 1;
        tick();
        idle(); div_done = 1;
        #1;
        chk("rb_late_done_es", 64'(es_stall), 64'h0);
        tick();
        idle();
        #1;
        chk("rb_late_done_rdy", 64'(div_ready), 64'h1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
